// File: rtl/uart_mmio_bridge.sv
// Memory-mapped bridge between the core data bus and a UART RX/TX pair.
// RX bytes are buffered with their parity flag; TX bytes are queued and handed to the transmitter one at a time.
module uart_mmio_bridge #(
    parameter int RX_DEPTH    = 8,
    parameter int TX_DEPTH    = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_parity_err,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    input  logic [3:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq_rx
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = $clog2(RX_DEPTH + 1);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = $clog2(TX_DEPTH + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

    logic [8:0]       rx_mem_q [RX_DEPTH];
    logic [8:0]       rx_mem_d [RX_DEPTH];
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       tx_mem_d [TX_DEPTH];
    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [2:0]       sticky_q, sticky_d;
    state_t           state_q, state_d;

    logic sel_data, sel_stat, rx_empty, rx_full, tx_empty, tx_full, tx_idle;
    logic rx_pop, rx_push, tx_wr, tx_pop, tx_push;
    logic [2:0] sticky_set, sticky_clr;
    logic unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

    assign sel_data = (bus_addr[3:2] == 2'd0);
    assign sel_stat = (bus_addr[3:2] == 2'd1);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_FULL);
    assign tx_idle  = tx_empty && (state_q == IDLE);

    // A pop on an empty FIFO is suppressed, so a coincident push into an empty RX FIFO is kept.
    assign rx_pop  = bus_re && sel_data && !rx_empty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign tx_pop  = (state_q == IDLE) && !tx_empty;
    assign tx_wr   = bus_we && sel_data;
    assign tx_push = tx_wr && (!tx_full || tx_pop);

    // Sticky bits {tx_overflow, rx_parity_seen, rx_overrun}; set takes priority over W1C.
    assign sticky_set = {tx_wr && tx_full && !tx_pop,
                         rx_valid && rx_parity_err,
                         rx_valid && rx_full && !rx_pop};
    assign sticky_clr = (bus_we && sel_stat) ? bus_wdata[6:4] : 3'b000;

    always_comb begin
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = {rx_parity_err, rx_data};
            rx_wptr_d = rx_wptr_q + RX_AW'(1);
        end
        if (rx_pop)
            rx_rptr_d = rx_rptr_q + RX_AW'(1);
        if (rx_push && !rx_pop)
            rx_cnt_d = rx_cnt_q + RX_CW'(1);
        else if (rx_pop && !rx_push)
            rx_cnt_d = rx_cnt_q - RX_CW'(1);
    end

    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        tx_data_d = tx_data_q;
        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = bus_wdata[7:0];
            tx_wptr_d = tx_wptr_q + TX_AW'(1);
        end
        if (tx_pop) begin
            tx_data_d = tx_mem_q[tx_rptr_q];
            tx_rptr_d = tx_rptr_q + TX_AW'(1);
        end
        if (tx_push && !tx_pop)
            tx_cnt_d = tx_cnt_q + TX_CW'(1);
        else if (tx_pop && !tx_push)
            tx_cnt_d = tx_cnt_q - TX_CW'(1);
        sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
    end

    // TX FSM next state; a missing busy acknowledge counts the byte as sent.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            IDLE:    if (!tx_empty) state_d = LAUNCH;
            LAUNCH: begin
                state_d  = WAIT_HI;
                to_cnt_d = '0;
            end
            WAIT_HI: begin
                if (tx_busy)
                    state_d = WAIT_LO;
                else if (to_cnt_q == TO_LAST)
                    state_d = IDLE;
                else
                    to_cnt_d = to_cnt_q + TO_W'(1);
            end
            WAIT_LO: if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_send = (state_q == LAUNCH);
        tx_data = tx_data_q;
        irq_rx  = !rx_empty;
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_re) begin
            if (sel_data && !rx_empty)
                bus_rdata = {23'b0, rx_mem_q[rx_rptr_q]};
            else if (sel_stat)
                bus_rdata = {25'b0, sticky_q, tx_idle, tx_full, rx_full, !rx_empty};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            to_cnt_q  <= '0;
            tx_data_q <= '0;
            sticky_q  <= '0;
            state_q   <= IDLE;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            to_cnt_q  <= to_cnt_d;
            tx_data_q <= tx_data_d;
            sticky_q  <= sticky_d;
            state_q   <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed self-checking bench for uart_mmio_bridge: RX path, status/W1C, TX handshake, timeout and reset.
module tb_uart_mmio_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_parity_err = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        irq_rx;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_mode = 0;
    int busy_cnt = 0;
    int send_cnt = 0;
    int dbl_cnt = 0;
    logic prev_send = 1'b0;
    int send_cyc [8];
    logic [7:0] send_dat [8];
    logic send_bsy [8];

    uart_mmio_bridge dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_valid(rx_valid), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .irq_rx(irq_rx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Transmitter model: 0 = busy tied low, 1 = busy for 10 cycles starting the cycle after tx_send, 2 = busy held high.
    always @(posedge clock) begin
        if (busy_mode == 2) tx_busy <= 1'b1;
        else if (busy_mode == 0) tx_busy <= 1'b0;
        else if (tx_send) begin tx_busy <= 1'b1; busy_cnt <= 10; end
        else if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
        else if (busy_cnt == 1) begin busy_cnt <= 0; tx_busy <= 1'b0; end
    end

    always @(negedge clock) begin
        if (tx_send && prev_send) dbl_cnt++;
        if (tx_send && send_cnt < 8) begin
            send_cyc[send_cnt] = cyc;
            send_dat[send_cnt] = tx_data;
            send_bsy[send_cnt] = tx_busy;
        end
        if (tx_send) send_cnt++;
        prev_send = tx_send;
    end

    task automatic rx_push(input logic [7:0] b, input logic pe);
        rx_valid = 1'b1; rx_data = b; rx_parity_err = pe;
        @(posedge clock); #1;
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] v);
        bus_we = 1'b1; bus_addr = a; bus_wdata = v;
        @(posedge clock); #1;
        bus_we = 1'b0; bus_wdata = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
        bus_re = 1'b1; bus_addr = a;
        #1 v = bus_rdata;
        @(posedge clock); #1;
        bus_re = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [31:0] v);
        bus_re = 1'b1; bus_addr = a;
        #1 v = bus_rdata;
        bus_re = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin @(posedge clock); #1; end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        peek(4'h4, d);
        tests++; if (d !== 32'h8) begin fails++; $display("FAIL reset_status: got %h want %h", d, 32'h8); end
        peek(4'h0, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want %h", d, 32'h0); end
        tests++; if (irq_rx !== 1'b0 || tx_send !== 1'b0 || tx_data !== 8'h0)
            begin fails++; $display("FAIL reset_outputs: got irq=%b send=%b data=%h want 0 0 00", irq_rx, tx_send, tx_data); end
        bus_addr = 4'h4; #1;
        tests++; if (bus_rdata !== 32'h0) begin fails++; $display("FAIL rdata_no_re: got %h want 0", bus_rdata); end
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        logic [31:0] exp [3];
        exp[0] = 32'h041; exp[1] = 32'h142; exp[2] = 32'h043;
        rx_push(8'h41, 1'b0);
        rx_push(8'h42, 1'b1);
        rx_push(8'h43, 1'b0);
        peek(4'h4, d);
        tests++; if (d !== 32'h29) begin fails++; $display("FAIL rx3_status: got %h want %h", d, 32'h29); end
        tests++; if (irq_rx !== 1'b1) begin fails++; $display("FAIL rx3_irq: got %b want 1", irq_rx); end
        for (int i = 0; i < 3; i++) begin
            bus_read(4'h0, d);
            tests++; if (d !== exp[i]) begin fails++; $display("FAIL rx_read%0d: got %h want %h", i, d, exp[i]); end
        end
        peek(4'h4, d);
        tests++; if (d !== 32'h28) begin fails++; $display("FAIL rx_drained_status: got %h want %h", d, 32'h28); end
        tests++; if (irq_rx !== 1'b0) begin fails++; $display("FAIL rx_drained_irq: got %b want 0", irq_rx); end
        bus_read(4'h0, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rx_empty_read: got %h want 0", d); end
        bus_write(4'h4, 32'h20);
        peek(4'h4, d);
        tests++; if (d !== 32'h08) begin fails++; $display("FAIL perr_w1c: got %h want %h", d, 32'h08); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) rx_push(8'(8'h10 + i), 1'b0);
        peek(4'h4, d);
        tests++; if (d !== 32'h1B) begin fails++; $display("FAIL overrun_status: got %h want %h", d, 32'h1B); end
        // Overrun set and W1C of the same bit in one cycle.
        rx_valid = 1'b1; rx_data = 8'h99;
        bus_we = 1'b1; bus_addr = 4'h4; bus_wdata = 32'h10;
        @(posedge clock); #1;
        rx_valid = 1'b0; bus_we = 1'b0; bus_wdata = '0;
        peek(4'h4, d);
        tests++; if (d !== 32'h1B) begin fails++; $display("FAIL set_wins: got %h want %h", d, 32'h1B); end
        bus_write(4'h4, 32'h10);
        peek(4'h4, d);
        tests++; if (d !== 32'h0B) begin fails++; $display("FAIL overrun_w1c: got %h want %h", d, 32'h0B); end
        for (int i = 0; i < 8; i++) begin
            bus_read(4'h0, d);
            tests++; if (d !== 32'h10 + 32'(i)) begin fails++; $display("FAIL overrun_read%0d: got %h want %h", i, d, 32'h10 + 32'(i)); end
        end
        peek(4'h4, d);
        tests++; if (d !== 32'h08) begin fails++; $display("FAIL overrun_drained: got %h want %h", d, 32'h08); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) rx_push(8'(8'h20 + i), 1'b0);
        peek(4'h4, d);
        tests++; if (d !== 32'h0B) begin fails++; $display("FAIL fill8_status: got %h want %h", d, 32'h0B); end
        // Pop and push together while full.
        rx_valid = 1'b1; rx_data = 8'h28;
        bus_re = 1'b1; bus_addr = 4'h0;
        #1 d = bus_rdata;
        @(posedge clock); #1;
        rx_valid = 1'b0; bus_re = 1'b0;
        tests++; if (d !== 32'h20) begin fails++; $display("FAIL full_pushpop_read: got %h want %h", d, 32'h20); end
        peek(4'h4, d);
        tests++; if (d !== 32'h0B) begin fails++; $display("FAIL full_pushpop_status: got %h want %h", d, 32'h0B); end
        peek(4'h8, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL addr8_read: got %h want 0", d); end
        bus_write(4'hC, 32'hFFFF_FFFF);
        peek(4'h4, d);
        tests++; if (d !== 32'h0B) begin fails++; $display("FAIL addrC_write: got %h want %h", d, 32'h0B); end
        for (int i = 0; i < 8; i++) begin
            bus_read(4'h0, d);
            tests++; if (d !== 32'h21 + 32'(i)) begin fails++; $display("FAIL b2b_read%0d: got %h want %h", i, d, 32'h21 + 32'(i)); end
        end
        // Pop and push together while empty: the pop is ignored.
        rx_valid = 1'b1; rx_data = 8'h77;
        bus_re = 1'b1; bus_addr = 4'h0;
        #1 d = bus_rdata;
        @(posedge clock); #1;
        rx_valid = 1'b0; bus_re = 1'b0;
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL empty_pushpop_read: got %h want 0", d); end
        bus_read(4'h0, d);
        tests++; if (d !== 32'h077) begin fails++; $display("FAIL empty_pushpop_kept: got %h want %h", d, 32'h077); end
        peek(4'h4, d);
        tests++; if (d !== 32'h08) begin fails++; $display("FAIL b2b_end_status: got %h want %h", d, 32'h08); end
    endtask

    task automatic test_tx_handshake();
        logic [31:0] d;
        int w;
        busy_mode = 1; send_cnt = 0; dbl_cnt = 0;
        w = cyc;
        bus_write(4'h0, 32'h55);
        bus_write(4'h0, 32'hAA);
        wait_until(w + 26);
        peek(4'h4, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL tx_busy_status: got %h want 0", d); end
        wait_until(w + 27);
        peek(4'h4, d);
        tests++; if (d !== 32'h08) begin fails++; $display("FAIL tx_idle_end: got %h want %h", d, 32'h08); end
        tests++; if (send_cnt !== 2 || dbl_cnt !== 0) begin fails++; $display("FAIL tx_pulses: got %0d pulses %0d long want 2 and 0", send_cnt, dbl_cnt); end
        tests++; if (send_dat[0] !== 8'h55 || send_dat[1] !== 8'hAA)
            begin fails++; $display("FAIL tx_data_order: got %h %h want 55 aa", send_dat[0], send_dat[1]); end
        tests++; if (send_cyc[0] !== w + 2 || send_cyc[1] !== w + 15 || send_bsy[1] !== 1'b0)
            begin fails++; $display("FAIL tx_timing: got %0d %0d busy=%b want %0d %0d busy=0", send_cyc[0] - w, send_cyc[1] - w, send_bsy[1], 2, 15); end
        busy_mode = 0;
    endtask

    task automatic test_tx_timeout();
        logic [31:0] d;
        int w;
        busy_mode = 0; send_cnt = 0;
        w = cyc;
        bus_write(4'h0, 32'h33);
        wait_until(w + 18);
        peek(4'h4, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL timeout_wait: got %h want 0", d); end
        wait_until(w + 19);
        peek(4'h4, d);
        tests++; if (d !== 32'h08) begin fails++; $display("FAIL timeout_idle: got %h want %h", d, 32'h08); end
        tests++; if (send_cnt !== 1 || send_cyc[0] !== w + 2 || send_dat[0] !== 8'h33)
            begin fails++; $display("FAIL timeout_send: got n=%0d at %0d data %h want 1 at 2 data 33", send_cnt, send_cyc[0] - w, send_dat[0]); end
    endtask

    task automatic test_tx_overflow_reset();
        logic [31:0] d;
        busy_mode = 2;
        repeat (2) begin @(posedge clock); #1; end
        bus_write(4'h0, 32'hA0);
        repeat (5) begin @(posedge clock); #1; end
        for (int i = 0; i < 8; i++) bus_write(4'h0, 32'(8'hB0 + i));
        peek(4'h4, d);
        tests++; if (d !== 32'h04) begin fails++; $display("FAIL tx_full: got %h want %h", d, 32'h04); end
        bus_write(4'h0, 32'hC0);
        peek(4'h4, d);
        tests++; if (d !== 32'h44) begin fails++; $display("FAIL tx_overflow: got %h want %h", d, 32'h44); end
        reset = 1'b1;
        @(posedge clock); #1;
        peek(4'h4, d);
        tests++; if (d !== 32'h08) begin fails++; $display("FAIL midreset_status: got %h want %h", d, 32'h08); end
        tests++; if (tx_send !== 1'b0 || tx_data !== 8'h0 || irq_rx !== 1'b0)
            begin fails++; $display("FAIL midreset_outputs: got send=%b data=%h irq=%b want 0 00 0", tx_send, tx_data, irq_rx); end
        reset = 1'b0;
        busy_mode = 0;
        repeat (3) begin @(posedge clock); #1; end
        peek(4'h4, d);
        tests++; if (d !== 32'h08) begin fails++; $display("FAIL postreset_status: got %h want %h", d, 32'h08); end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_rx_overrun();
        test_back_to_back();
        test_tx_handshake();
        test_tx_timeout();
        test_tx_overflow_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- Memory-mapped glue between the single-cycle RISC-V core's data bus and the UART transmit/receive pair.
- Buffers received bytes in an RX FIFO and exposes them through DATA/STATUS registers.
- Queues core-written bytes in a TX FIFO and drives the transmitter's send strobe, one byte at a time, with a busy handshake.
- Sits directly downstream of the UART receiver and directly upstream of the UART transmitter.

Parameters:
- RX_DEPTH, 8, RX FIFO entries (power of 2, ≥2).
- TX_DEPTH, 8, TX FIFO entries (power of 2, ≥2).
- ACK_TIMEOUT, 16, max cycles to wait for tx_busy to rise after a send strobe.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte from UART receiver.
- rx_parity_err  in  1  parity error flag accompanying rx_data.
- rx_valid  in  1  one-cycle strobe: rx_data/rx_parity_err valid.
- tx_data  out  8  byte presented to UART transmitter.
- tx_send  out  1  one-cycle send strobe to transmitter.
- tx_busy  in  1  transmitter busy (high while shifting).
- bus_addr  in  4  byte address; bits [3:2] decoded.
- bus_we  in  1  write enable.
- bus_re  in  1  read enable.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, combinational.
- irq_rx  out  1  high while RX FIFO is non-empty.

Behaviour:
- Reset: FIFOs empty, pointers 0, sticky bits 0, FSM=IDLE, tx_data=0, tx_send=0, irq_rx=0, bus_rdata=0.
- Address map:
  - 0x0 DATA: read returns {23'b0, perr, byte} of the RX head; write pushes bus_wdata[7:0] into the TX FIFO.
  - 0x4 STATUS: read only, plus W1C bits (see below).
  - 0x8 and 0xC: read 0, writes ignored.
- STATUS bits:
  - [0] rx_not_empty.
  - [1] rx_full.
  - [2] tx_full.
  - [3] tx_idle = TX FIFO empty and FSM=IDLE.
  - [4] rx_overrun (sticky, W1C).
  - [5] rx_parity_seen (sticky, W1C).
  - [6] tx_overflow (sticky, W1C).
  - [31:7] = 0.
  - W1C: writing 1 to bit 4, 5 or 6 of STATUS clears that bit.
  - If a set event and a clear of the same bit occur in the same cycle, the set wins.
- Read timing: bus_rdata is combinational from the current address and state, so a read completes in the same cycle, matching the single-cycle core. With bus_re=0, bus_rdata=0.
- RX pop: occurs at the clock edge when bus_re=1 and addr=0x0 and the RX FIFO is non-empty.
  - Reading DATA while empty returns 0 and leaves pointers unchanged.
- RX push: occurs when rx_valid=1. Each entry stores 9 bits, {perr, byte}.
  - If rx_parity_err=1, rx_parity_seen is set regardless of FIFO state.
  - If full with no simultaneous pop: byte dropped, rx_overrun set, contents unchanged.
  - If full with a simultaneous pop: push accepted, occupancy stays full.
  - Simultaneous push and pop when empty: the pushed byte is stored and the pop is ignored, because the read returned 0.
- TX push: occurs when bus_we=1 and addr=0x0.
  - If full with no simultaneous FSM pop: byte dropped, tx_overflow set.
  - Simultaneous push and FSM pop when full: accepted.
- TX FSM:
  - IDLE: if the TX FIFO is non-empty, pop the head into tx_data and go to LAUNCH.
  - LAUNCH: tx_send=1 for exactly this cycle; go to WAIT_HI and clear the timeout counter.
  - WAIT_HI: on tx_busy=1, go to WAIT_LO. If the counter reaches ACK_TIMEOUT-1, go to IDLE and count the byte as sent (no retry).
  - WAIT_LO: on tx_busy=0, go to IDLE.
  - tx_data holds its value until the next pop.
  - Minimum spacing between tx_send strobes is 4 cycles.
- irq_rx = rx_not_empty, registered from FIFO state (no extra latency beyond occupancy update).
- FIFO counters are wide enough for depth + 1 values; pointers wrap modulo depth.
- Reset asserted mid-operation: everything returns to reset values on the next edge, queued bytes are discarded, and tx_send is deasserted immediately on that edge.

Test Plan:
- Reset, then read STATUS -> 0x00000008 (tx_idle only); read DATA -> 0; irq_rx=0.
- Three rx_valid pulses with 0x41, 0x42 (parity_err=1), 0x43 -> STATUS bits[0]=1 and [5]=1. DATA reads return 0x041, 0x142, 0x043 in that order, then STATUS[0]=0 and irq_rx=0.
- Nine rx_valid pulses with no reads (RX_DEPTH=8) -> STATUS[1]=1 and [4]=1; eight reads return the first eight bytes. Writing 0x10 to STATUS clears bit 4.
- Write 0x55 and 0xAA to DATA with a tx_busy model (rises 1 cycle after tx_send, stays high 10 cycles) -> two single-cycle tx_send pulses, tx_data 0x55 then 0xAA, second pulse only after tx_busy falls. STATUS[3]=1 at the end.
- tx_busy tied 0 and one byte written -> tx_send pulse; FSM returns to IDLE after 16 WAIT_HI cycles; STATUS[3]=1.
- tx_busy held 1 and nine TX writes -> STATUS[2]=1 and [6]=1. Reset asserted mid-transfer -> next cycle STATUS=0x08 and tx_send=0.
